mdu_hilo: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Operands are taken from the register-file read ports (rs/rt data) in execute.
- HI/LO are driven back toward register-file writeback for MFHI/MFLO.
- busy lets the pipeline stall dependent MFHI/MFLO and new MDU ops until results land.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_hilo.sv | 136 +++++++++++++
 tb/tb_mdu_hilo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states
// and the divide-by-zero quotient pattern.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Wide enough for any operand width up to 64; the unit slices what it needs.
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle over a shared accumulator.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opB;
  logic [WIDTH-1:0]   rawA;
  logic               isDiv;
  logic               negRes;
  logic               negRem;
  logic               divZero;

  logic               opSigned;
  logic               negA;
  logic               negB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    opSigned = (op == OP_MULT) || (op == OP_DIV);
    negA     = opSigned & rs_data[WIDTH-1];
    negB     = opSigned & rt_data[WIDTH-1];
    magA     = negA ? -rs_data : rs_data;
    magB     = negB ? -rt_data : rt_data;

    // Multiply: low half holds the remaining multiplier bits, high half the partial product.
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
    // Divide: high half is the partial remainder, low half shifts in quotient bits.
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opB};

    if (isDiv) begin
      if (trial[WIDTH])
        accNext = {acc[2*WIDTH-2:0], 1'b0};
      else
        accNext = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      accNext = {mulSum, acc[WIDTH-1:1]};
    end

    prod = negRes ? -acc : acc;
    quot = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opB     <= '0;
      rawA    <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (op)
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                isDiv   <= op[1];
                acc     <= {{WIDTH{1'b0}}, magA};
                opB     <= magB;
                rawA    <= rs_data;
                negRes  <= negA ^ negB;
                negRem  <= negA;
                divZero <= (rt_data == '0);
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= accNext;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          if (!isDiv) begin
            {hi, lo} <= prod;
          end else if (divZero) begin
            hi <= rawA;
            lo <= DIV0_LO[WIDTH-1:0];
          end else begin
            hi <= rem;
            lo <= quot;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI:LO from a plain-arithmetic model,
// checked by a monitor on every done pulse.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rsData = '0;
  logic [31:0] rtData = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int fails  = 0;

  logic [63:0] sb[$];
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rsData), .rt_data(rtData),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sp;
    longint unsigned up;
    int sa, sb2, q, r;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      3'd1: begin
        up = longint'({32'b0, a}) * longint'({32'b0, b});
        return 64'(up);
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a; sb2 = b;
        q = sa / sb2; r = sa % sb2;
        return {32'(r), 32'(q)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {modelHi, modelLo};
    endcase
  endfunction

  // Drive one request; when accepted, update the architectural model.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit accepted);
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; rsData = a; rtData = b;
    @(posedge clk);
    #1 start = 1'b0;
    if (accepted) begin
      if (o <= 3'd3) begin
        e = refModel(o, a, b);
        sb.push_back(e);
        modelHi = e[63:32];
        modelLo = e[31:0];
      end else begin
        if (o == 3'd4) modelHi = a;
        if (o == 3'd5) modelLo = a;
        check("mt_hi", 64'(hi), 64'(modelHi));
        check("mt_lo", 64'(lo), 64'(modelLo));
        check("mt_busy", 64'(busy), 64'(0));
        check("mt_done", 64'(done), 64'(0));
      end
    end else begin
      check("busy_held", 64'(busy), 64'(1));
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++; fails++;
    $display("FAIL waitIdle: busy still %0b after 100 cycles, required 0", busy);
  endtask

  // Monitor: busy length, HI/LO stability while busy, and done against scoreboard.
  int          busyCnt = 0;
  bit          havePrev = 0;
  logic [31:0] prevHi, prevLo;
  logic [63:0] exp;
  always @(negedge clk) begin
    if (!rst) begin
      busyCnt  = 0;
      havePrev = 0;
    end else begin
      if (busy) begin
        if (havePrev) begin
          check("hi_stable", 64'(hi), 64'(prevHi));
          check("lo_stable", 64'(lo), 64'(prevLo));
        end
        prevHi = hi; prevLo = lo; havePrev = 1;
        busyCnt++;
      end
      if (done) begin
        check("busy_len", 64'(busyCnt), 64'(33));
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL spurious_done: done=1 with no op outstanding, required 0");
        end else begin
          exp = sb.pop_front();
          check("res_hi", 64'(hi), 64'(exp[63:32]));
          check("res_lo", 64'(lo), 64'(exp[31:0]));
        end
        busyCnt  = 0;
        havePrev = 0;
      end
    end
  end

  logic [2:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clk); rst = 1'b1;

    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1); waitIdle();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); waitIdle();
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1); waitIdle();
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1); waitIdle();
    issue(3'd3, 32'h0000_0007, 32'h0000_0002, 1); waitIdle();
    issue(3'd2, 32'h0000_0005, 32'h0000_0000, 1); waitIdle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1); waitIdle();
    issue(3'd4, 32'h0000_1234, 32'h0, 1);
    issue(3'd6, 32'hDEAD_BEEF, 32'h0, 1);

    issue(3'd2, 32'h0000_0064, 32'hFFFF_FFF9, 1);
    repeat (3) @(negedge clk);
    issue(3'd5, 32'hCAFE_F00D, 32'h0, 0);
    issue(3'd0, 32'h0000_0011, 32'h0000_0013, 0);
    waitIdle();

    issue(3'd2, 32'h1234_5678, 32'h0000_0009, 1);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    sb.delete();
    modelHi = '0; modelLo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(3'd0, 32'd6, 32'd7, 1); waitIdle();

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'(($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h1);
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(ro, ra, rb, 1);
      waitIdle();
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
